// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite response encoding and FSM state types for the decode-error slave.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_GOT_AW = 2'd1,
    W_GOT_W  = 2'd2,
    W_RESP   = 2'd3
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } rd_state_t;

endpackage

// File: rtl/axi_lite_sat_cnt.sv
// Saturating event counter: +1 per inc cycle, sticks at all-ones; async active-high reset.
module axi_lite_sat_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != {WIDTH{1'b1}})) begin
      cnt <= cnt + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/axi_lite_decerr_slave.sv
// Default AXI-Lite slave: every access answers DECERR one cycle after its last address/data handshake,
// one outstanding per channel, readies are registered; error stats only with AXI_LITE_DECERR_CNT_EN.
module axi_lite_decerr_slave
  import axi_lite_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] DECERR_RDATA = 32'hDEAD_BEEF,
  parameter int                    CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [CNT_WIDTH-1:0]    wr_err_cnt,
  output logic [CNT_WIDTH-1:0]    rd_err_cnt,
  output logic [ADDR_WIDTH-1:0]   last_err_addr
);

  wr_state_t             wr_state;
  rd_state_t             rd_state;
  logic                  awready_q, wready_q, arready_q;
  logic                  bvalid_q, rvalid_q;
  resp_t                 bresp_q, rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs;

  // Ready flops reset high so the slave is ready as soon as rst drops; rst masks them meanwhile.
  assign awready = awready_q & ~rst;
  assign wready  = wready_q & ~rst;
  assign arready = arready_q & ~rst;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign rvalid  = rvalid_q;
  assign rresp   = rresp_q;
  assign rdata   = rdata_q;

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;
  assign b_hs  = bvalid & bready;
  assign ar_hs = arvalid & arready;
  assign r_hs  = rvalid & rready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state  <= W_IDLE;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (aw_hs && w_hs) begin
            wr_state  <= W_RESP;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= RESP_DECERR;
          end else if (aw_hs) begin
            wr_state  <= W_GOT_AW;
            awready_q <= 1'b0;
          end else if (w_hs) begin
            wr_state <= W_GOT_W;
            wready_q <= 1'b0;
          end
        end
        W_GOT_AW: begin
          if (w_hs) begin
            wr_state <= W_RESP;
            wready_q <= 1'b0;
            bvalid_q <= 1'b1;
            bresp_q  <= RESP_DECERR;
          end
        end
        W_GOT_W: begin
          if (aw_hs) begin
            wr_state  <= W_RESP;
            awready_q <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= RESP_DECERR;
          end
        end
        W_RESP: begin
          if (bready) begin
            wr_state  <= W_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            bvalid_q  <= 1'b0;
          end
        end
        default: begin
          wr_state  <= W_IDLE;
          awready_q <= 1'b1;
          wready_q  <= 1'b1;
          bvalid_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state  <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (ar_hs) begin
            rd_state  <= R_RESP;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rresp_q   <= RESP_DECERR;
            rdata_q   <= DECERR_RDATA;
          end
        end
        R_RESP: begin
          if (rready) begin
            rd_state  <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
          end
        end
        default: begin
          rd_state  <= R_IDLE;
          arready_q <= 1'b1;
          rvalid_q  <= 1'b0;
          rdata_q   <= '0;
        end
      endcase
    end
  end

`ifdef AXI_LITE_DECERR_CNT_EN
  logic [ADDR_WIDTH-1:0] last_err_addr_q;

  axi_lite_sat_cnt #(.WIDTH(CNT_WIDTH)) u_wr_cnt (
    .clk (clk),
    .rst (rst),
    .inc (b_hs),
    .cnt (wr_err_cnt)
  );

  axi_lite_sat_cnt #(.WIDTH(CNT_WIDTH)) u_rd_cnt (
    .clk (clk),
    .rst (rst),
    .inc (r_hs),
    .cnt (rd_err_cnt)
  );

  // A read address landing in the same cycle as a write address takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_err_addr_q <= '0;
    end else if (ar_hs) begin
      last_err_addr_q <= araddr;
    end else if (aw_hs) begin
      last_err_addr_q <= awaddr;
    end
  end

  assign last_err_addr = last_err_addr_q;

  logic unused_wr_payload;
  assign unused_wr_payload = ^{wdata, wstrb};
`else
  assign wr_err_cnt    = '0;
  assign rd_err_cnt    = '0;
  assign last_err_addr = '0;

  // Write payload and addresses are dropped entirely when statistics are off.
  logic unused_inputs;
  assign unused_inputs = ^{wdata, wstrb, awaddr, araddr, b_hs, r_hs};
`endif

endmodule

// File: tb/tb_axi_lite_decerr_slave.sv
// Self-checking bench for axi_lite_decerr_slave: scoreboard queues of expected B/R responses.
module tb_axi_lite_decerr_slave;

`ifdef AXI_LITE_DECERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  localparam logic [31:0] RD_PAT = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] awaddr = '0, araddr = '0, wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata, last_err_addr;
  logic [15:0] wr_err_cnt, rd_err_cnt;

  // Second instance with a narrow counter for the saturation scenario.
  logic [31:0] s_araddr = '0, s_rdata, s_last;
  logic        s_arvalid = 0, s_rready = 0, s_arready, s_rvalid;
  logic        s_awready, s_wready, s_bvalid;
  logic [1:0]  s_bresp, s_rresp;
  logic [3:0]  s_wr_cnt, s_rd_cnt;

  int total = 0;
  int bad   = 0;
  int exp_wr = 0, exp_rd = 0;
  logic [31:0] exp_last = '0;
  logic [1:0]  wq[$];
  logic [31:0] rq[$];

  always #5 clk = ~clk;

  axi_lite_decerr_slave dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .wr_err_cnt(wr_err_cnt), .rd_err_cnt(rd_err_cnt), .last_err_addr(last_err_addr)
  );

  axi_lite_decerr_slave #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst),
    .awaddr(32'h0), .awvalid(1'b0), .awready(s_awready),
    .wdata(32'h0), .wstrb(4'h0), .wvalid(1'b0), .wready(s_wready),
    .bresp(s_bresp), .bvalid(s_bvalid), .bready(1'b1),
    .araddr(s_araddr), .arvalid(s_arvalid), .arready(s_arready),
    .rdata(s_rdata), .rresp(s_rresp), .rvalid(s_rvalid), .rready(s_rready),
    .wr_err_cnt(s_wr_cnt), .rd_err_cnt(s_rd_cnt), .last_err_addr(s_last)
  );

  function automatic int cnt_exp(input int n, input int maxv);
    if (!CNT_EN) return 0;
    return (n > maxv) ? maxv : n;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    total++; if ({awready, wready, arready} !== 3'b000) begin bad++; $display("FAIL reset_ready got=%b want=000", {awready, wready, arready}); end
    total++; if ({bvalid, rvalid, bresp, rresp} !== 6'b0) begin bad++; $display("FAIL reset_resp got=%b want=0", {bvalid, rvalid, bresp, rresp}); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", rdata); end
    total++; if ({wr_err_cnt, rd_err_cnt, last_err_addr} !== 64'h0) begin bad++; $display("FAIL reset_stats got=%h want=0", {wr_err_cnt, rd_err_cnt, last_err_addr}); end
    #2 rst = 1'b0;
    #1;
    total++; if ({awready, wready, arready} !== 3'b111) begin bad++; $display("FAIL release_ready got=%b want=111", {awready, wready, arready}); end
  endtask

  task automatic test_same_cycle();
    logic [1:0] e;
    @(negedge clk);
    awaddr = 32'h5000; awvalid = 1; wvalid = 1; wdata = 32'h1234; wstrb = 4'hf; bready = 1;
    total++; if ({awready, wready} !== 2'b11) begin bad++; $display("FAIL sc_ready got=%b want=11", {awready, wready}); end
    wq.push_back(2'b11); exp_last = 32'h5000;
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    total++; if (bvalid !== 1'b1) begin bad++; $display("FAIL sc_bvalid got=%b want=1", bvalid); end
    e = wq.pop_front();
    total++; if (bresp !== e) begin bad++; $display("FAIL sc_bresp got=%b want=%b", bresp, e); end
    total++; if ({awready, wready} !== 2'b00) begin bad++; $display("FAIL sc_busy_ready got=%b want=00", {awready, wready}); end
    exp_wr++;
    @(negedge clk);
    total++; if ({bvalid, awready, wready} !== 3'b011) begin bad++; $display("FAIL sc_after got=%b want=011", {bvalid, awready, wready}); end
    total++; if (wr_err_cnt !== 16'(cnt_exp(exp_wr, 65535))) begin bad++; $display("FAIL sc_wr_cnt got=%0d want=%0d", wr_err_cnt, cnt_exp(exp_wr, 65535)); end
    total++; if (last_err_addr !== (CNT_EN ? exp_last : 32'h0)) begin bad++; $display("FAIL sc_last got=%h want=%h", last_err_addr, CNT_EN ? exp_last : 32'h0); end
  endtask

  task automatic test_w_then_aw();
    logic [1:0] e;
    @(negedge clk);
    wvalid = 1; bready = 1;
    wq.push_back(2'b11);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      wvalid = 0;
      total++; if ({wready, awready, bvalid} !== 3'b010) begin bad++; $display("FAIL wa_cycle%0d got=%b want=010", c, {wready, awready, bvalid}); end
      if (c == 3) begin awaddr = 32'h6000; awvalid = 1; exp_last = 32'h6000; end
    end
    @(negedge clk);
    awvalid = 0;
    total++; if (bvalid !== 1'b1) begin bad++; $display("FAIL wa_bvalid got=%b want=1", bvalid); end
    e = wq.pop_front();
    total++; if (bresp !== e) begin bad++; $display("FAIL wa_bresp got=%b want=%b", bresp, e); end
    exp_wr++;
    @(negedge clk);
    total++; if ({bvalid, wready} !== 2'b01) begin bad++; $display("FAIL wa_after got=%b want=01", {bvalid, wready}); end
    total++; if (last_err_addr !== (CNT_EN ? exp_last : 32'h0)) begin bad++; $display("FAIL wa_last got=%h want=%h", last_err_addr, CNT_EN ? exp_last : 32'h0); end
  endtask

  task automatic test_read_hold();
    logic [31:0] e;
    @(negedge clk);
    araddr = 32'h9000; arvalid = 1; rready = 0;
    rq.push_back(RD_PAT); exp_last = 32'h9000;
    e = rq[0];
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      arvalid = 0;
      total++; if ({rvalid, rresp, arready} !== 4'b1110 || rdata !== e) begin bad++; $display("FAIL rh_hold%0d got=%b/%h want=1110/%h", c, {rvalid, rresp, arready}, rdata, e); end
    end
    rready = 1;
    e = rq.pop_front();
    total++; if (rdata !== e) begin bad++; $display("FAIL rh_final got=%h want=%h", rdata, e); end
    exp_rd++;
    @(negedge clk);
    rready = 0;
    total++; if ({rvalid, arready} !== 2'b01 || rdata !== 32'h0) begin bad++; $display("FAIL rh_after got=%b/%h want=01/0", {rvalid, arready}, rdata); end
    total++; if (rd_err_cnt !== 16'(cnt_exp(exp_rd, 65535))) begin bad++; $display("FAIL rh_rd_cnt got=%0d want=%0d", rd_err_cnt, cnt_exp(exp_rd, 65535)); end
    total++; if (last_err_addr !== (CNT_EN ? exp_last : 32'h0)) begin bad++; $display("FAIL rh_last got=%h want=%h", last_err_addr, CNT_EN ? exp_last : 32'h0); end
  endtask

  task automatic test_concurrent();
    int wiss = 0, riss = 0, bcnt = 0, rcnt = 0, cyc = 0;
    int wr0 = exp_wr, rd0 = exp_rd;
    logic [1:0] eb;
    logic [31:0] er;
    logic aw_go, ar_go;
    while ((bcnt < 100 || rcnt < 100) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      bready = 1'($urandom_range(0, 1));
      rready = 1'($urandom_range(0, 1));
      if (bvalid && bready) begin
        if (wq.size() == 0) begin total++; bad++; $display("FAIL cc_unexpected_b got=1 want=0"); end
        else begin
          eb = wq.pop_front();
          total++; if (bresp !== eb) begin bad++; $display("FAIL cc_bresp got=%b want=%b", bresp, eb); end
        end
        bcnt++; exp_wr++;
      end
      if (rvalid && rready) begin
        if (rq.size() == 0) begin total++; bad++; $display("FAIL cc_unexpected_r got=1 want=0"); end
        else begin
          er = rq.pop_front();
          total++; if (rdata !== er || rresp !== 2'b11) begin bad++; $display("FAIL cc_rdata got=%h/%b want=%h/11", rdata, rresp, er); end
        end
        rcnt++; exp_rd++;
      end
      awvalid = (wiss < 100); wvalid = (wiss < 100); awaddr = 32'h1000 + 32'(wiss) * 4;
      arvalid = (riss < 100); araddr = 32'h2000 + 32'(riss) * 4;
      aw_go = awvalid && awready && wvalid && wready;
      ar_go = arvalid && arready;
      if (aw_go) begin wq.push_back(2'b11); wiss++; end
      if (ar_go) begin rq.push_back(RD_PAT); riss++; end
      if (ar_go) exp_last = araddr;
      else if (aw_go) exp_last = awaddr;
    end
    @(negedge clk);
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
    total++; if (bcnt !== 100 || rcnt !== 100) begin bad++; $display("FAIL cc_count got=%0d/%0d want=100/100", bcnt, rcnt); end
    total++; if (wr_err_cnt !== 16'(cnt_exp(exp_wr, 65535))) begin bad++; $display("FAIL cc_wr_cnt got=%0d want=%0d", wr_err_cnt, cnt_exp(exp_wr, 65535)); end
    total++; if (rd_err_cnt !== 16'(cnt_exp(exp_rd, 65535))) begin bad++; $display("FAIL cc_rd_cnt got=%0d want=%0d", rd_err_cnt, cnt_exp(exp_rd, 65535)); end
    total++; if (CNT_EN && (exp_wr - wr0 != 100 || exp_rd - rd0 != 100)) begin bad++; $display("FAIL cc_delta got=%0d/%0d want=100/100", exp_wr - wr0, exp_rd - rd0); end
    total++; if (last_err_addr !== (CNT_EN ? exp_last : 32'h0)) begin bad++; $display("FAIL cc_last got=%h want=%h", last_err_addr, CNT_EN ? exp_last : 32'h0); end
  endtask

  task automatic test_saturate();
    int iss = 0, done = 0, cyc = 0;
    while (done < 20 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      s_rready = 1;
      if (s_rvalid) begin
        total++; if (s_rdata !== RD_PAT || s_rresp !== 2'b11) begin bad++; $display("FAIL sat_rdata got=%h/%b want=%h/11", s_rdata, s_rresp, RD_PAT); end
        done++;
      end
      s_arvalid = (iss < 20); s_araddr = 32'hA000 + 32'(iss);
      if (s_arvalid && s_arready) iss++;
    end
    @(negedge clk);
    s_arvalid = 0; s_rready = 0;
    total++; if (done !== 20) begin bad++; $display("FAIL sat_reads got=%0d want=20", done); end
    total++; if (s_rd_cnt !== 4'(cnt_exp(done, 15))) begin bad++; $display("FAIL sat_cnt got=%0d want=%0d", s_rd_cnt, cnt_exp(done, 15)); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    awvalid = 1; wvalid = 1; awaddr = 32'h7000; bready = 0;
    arvalid = 1; araddr = 32'h7100; rready = 0;
    @(negedge clk);
    awvalid = 0; wvalid = 0; arvalid = 0;
    total++; if ({bvalid, rvalid} !== 2'b11) begin bad++; $display("FAIL rm_pending got=%b want=11", {bvalid, rvalid}); end
    #2 rst = 1'b1;
    #1;
    wq.delete(); rq.delete(); exp_wr = 0; exp_rd = 0; exp_last = '0;
    total++; if ({bvalid, rvalid, awready, wready, arready} !== 5'b0) begin bad++; $display("FAIL rm_async got=%b want=00000", {bvalid, rvalid, awready, wready, arready}); end
    total++; if ({wr_err_cnt, rd_err_cnt, last_err_addr, s_rd_cnt} !== 68'h0) begin bad++; $display("FAIL rm_stats got=%h want=0", {wr_err_cnt, rd_err_cnt, last_err_addr, s_rd_cnt}); end
    @(negedge clk);
    rst = 1'b0; bready = 1; rready = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if ({bvalid, rvalid} !== 2'b00) begin bad++; $display("FAIL rm_no_resp%0d got=%b want=00", c, {bvalid, rvalid}); end
    end
    total++; if ({wr_err_cnt, rd_err_cnt} !== 32'h0) begin bad++; $display("FAIL rm_cnt got=%h want=0", {wr_err_cnt, rd_err_cnt}); end
    bready = 0; rready = 0;
  endtask

  initial begin
    test_reset();
    test_same_cycle();
    test_w_then_aw();
    test_read_hold();
    test_concurrent();
    test_saturate();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_lite_decerr_slave.md
AXI_LITE_DECERR_SLAVE -- requirements
Module: axi_lite_decerr_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning AWADDR/ARADDR width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning WDATA/RDATA width.
REQ-003 SHALL have parameter DECERR_RDATA, default 32'hDEAD_BEEF, meaning RDATA value returned on every read.
REQ-004 SHALL have parameter CNT_WIDTH, default 16, meaning error counter width.
REQ-005 SHALL use one clock and an asynchronous, active-high reset.
REQ-006 SHALL have these ports, listed as name, direction, width, meaning:
- clk, in, 1, clock.
- rst, in, 1, async active-high reset.
- awaddr, in, ADDR_WIDTH, write address.
- awvalid, in, 1; awready, out, 1.
- wdata, in, DATA_WIDTH; wstrb, in, DATA_WIDTH/8; wvalid, in, 1; wready, out, 1.
- bresp, out, 2; bvalid, out, 1; bready, in, 1.
- araddr, in, ADDR_WIDTH, read address; arvalid, in, 1; arready, out, 1.
- rdata, out, DATA_WIDTH; rresp, out, 2; rvalid, out, 1; rready, in, 1.
- wr_err_cnt, out, CNT_WIDTH, count of completed write errors.
- rd_err_cnt, out, CNT_WIDTH, count of completed read errors.
- last_err_addr, out, ADDR_WIDTH, address of the most recent accepted transaction.

Function
REQ-007 SHALL act as the default slave behind the address decoder: every accepted transaction completes with response DECERR (2'b11); wdata/wstrb are discarded.
REQ-008 Write FSM SHALL have states W_IDLE, W_GOT_AW, W_GOT_W, W_RESP.
- awready = 1 in W_IDLE and W_GOT_W only.
- wready = 1 in W_IDLE and W_GOT_AW only.
- bvalid = 1 in W_RESP only.
REQ-009 Write transitions:
- W_IDLE: AW and W in the same cycle -> W_RESP; AW only -> W_GOT_AW; W only -> W_GOT_W.
- W_GOT_AW: W -> W_RESP.
- W_GOT_W: AW -> W_RESP.
- W_RESP: bready -> W_IDLE.
REQ-010 bvalid SHALL assert exactly one cycle after the later of the AW/W handshakes, and SHALL hold with bresp stable until bready.
REQ-011 Read FSM SHALL have states R_IDLE (arready=1) and R_RESP (rvalid=1, rdata=DECERR_RDATA, rresp=2'b11); AR handshake -> R_RESP; rready -> R_IDLE.
REQ-012 rvalid SHALL assert one cycle after the AR handshake; rdata/rresp SHALL hold stable until rready.
REQ-013 No new AR SHALL be accepted while in R_RESP, and no new AW/W while in W_RESP: one outstanding transaction per channel.
REQ-014 Read and write paths SHALL be fully independent; simultaneous read and write activity SHALL proceed without interaction.
REQ-015 No ready output SHALL depend combinationally on any valid input.
REQ-016 rdata SHALL be 0 whenever rvalid = 0.

Reset
REQ-017 rst SHALL asynchronously force W_IDLE, R_IDLE, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, counters=0, last_err_addr=0.
REQ-018 awready, wready, and arready SHALL be 0 while rst = 1 and SHALL be 1 in the first cycle after release.
REQ-019 Reset mid-transaction SHALL drop the pending response with no completion and no counter increment.

Configuration
REQ-020 With AXI_LITE_DECERR_CNT_EN defined:
- wr_err_cnt increments on each B handshake; rd_err_cnt increments on each R handshake; both saturate at all-ones.
- last_err_addr captures awaddr/araddr on handshake; if AW and AR handshake in the same cycle, araddr wins.
REQ-021 Without AXI_LITE_DECERR_CNT_EN, wr_err_cnt, rd_err_cnt, and last_err_addr SHALL be constant 0 and no counter flops SHALL exist.

Structure
REQ-022 Package axi_lite_pkg SHALL hold the resp_t encoding (OKAY=00, EXOKAY=01, SLVERR=10, DECERR=11) and the wr_state_t/rd_state_t typedefs.
REQ-023 The saturating counter SHALL be sub-module axi_lite_sat_cnt (parameter WIDTH; ports inc, cnt), instantiated twice under the macro.

Verification
REQ-024 AW 0x5000 and W in the same cycle, bready=1 -> bvalid next cycle, bresp=2'b11, back to awready=1 the cycle after.
REQ-025 W at cycle 0, AW at cycle 3 -> wready=0 during cycles 1-3, bvalid at cycle 4.
REQ-026 AR 0x9000, rready held 0 for 5 cycles -> rvalid/rdata=0xDEADBEEF/rresp=2'b11 stable throughout, arready=0.
REQ-027 Concurrent write and read every cycle for 100 transactions -> 100 B and 100 R responses; with the macro, wr_err_cnt=rd_err_cnt=100.
REQ-028 CNT_WIDTH=4 with 20 reads -> rd_err_cnt saturates at 15.
REQ-029 Assert rst while bvalid=1 -> bvalid=0 immediately, counters=0, no B handshake.
